fp16_to_pixel8_packer: RTL and testbench

- Streaming inverse of the pixel-to-Q2.14 input path. Takes signed Q2.14 CNN results and rounds and clamps each one to an unsigned 8-bit pixel.
- Packs PACK_COUNT pixels per output word for write-back to the frame buffer or an external memory interface.
- Valid/ready handshake on both sides; 2-stage pipeline; counts saturation events for debug.

---
 rtl/fixed_point_pkg.sv | 12 +
 rtl/fp16_to_pixel8_round_sat.sv | 40 ++++
 rtl/fp16_to_pixel8_packer.sv | 131 +++++++++++++
 tb/tb_fp16_to_pixel8_packer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// rtl/fixed_point_pkg.sv - shared Q-format constants for the pixel <-> fixed-point paths
package fixed_point_pkg;

    localparam int Q_INTEGER   = 2;
    localparam int Q_FRACTION  = 14;
    localparam int Q_WIDTH     = Q_INTEGER + Q_FRACTION;
    localparam int PIXEL_WIDTH = 8;
    localparam int Q_SHIFT     = Q_FRACTION - PIXEL_WIDTH;
    localparam int ROUND_CONST = 1 << (Q_SHIFT - 1);
    localparam int PIXEL_MAX   = (1 << PIXEL_WIDTH) - 1;

endpackage

// File: rtl/fp16_to_pixel8_round_sat.sv
// rtl/fp16_to_pixel8_round_sat.sv - round-half-up and clamp of a signed Q value to an unsigned pixel
module fp16_to_pixel8_round_sat
    import fixed_point_pkg::*;
#(
    parameter int IN_INTEGER     = Q_INTEGER,
    parameter int IN_FRACTION    = Q_FRACTION,
    parameter int OUT_DATA_WIDTH = PIXEL_WIDTH
) (
    input  logic [IN_INTEGER+IN_FRACTION-1:0] fp_in,
    output logic [OUT_DATA_WIDTH-1:0]         pixel,
    output logic                              sat
);

    localparam int QW    = IN_INTEGER + IN_FRACTION;
    localparam int SHIFT = IN_FRACTION - OUT_DATA_WIDTH;
    localparam int RW    = QW + 1 - SHIFT;
    localparam logic [QW:0] ROUND = (QW + 1)'(1 << (SHIFT - 1));

    logic [QW:0]   sum;
    logic [RW-1:0] r;
    logic          neg;
    logic          over;

    // One guard bit keeps the rounding add from wrapping at the positive extreme.
    assign sum  = {fp_in[QW-1], fp_in} + ROUND;
    assign r    = RW'(sum >> SHIFT);
    assign neg  = r[RW-1];
    assign over = !neg && (|r[RW-2:OUT_DATA_WIDTH]);

    always_comb begin
        pixel = r[OUT_DATA_WIDTH-1:0];
        if (neg) begin
            pixel = '0;
        end else if (over) begin
            pixel = '1;
        end
        sat = neg || over;
    end

endmodule

// File: rtl/fp16_to_pixel8_packer.sv
// rtl/fp16_to_pixel8_packer.sv - streams Q values to clamped pixels packed PACK_COUNT per word
module fp16_to_pixel8_packer
    import fixed_point_pkg::*;
#(
    parameter int IN_INTEGER     = Q_INTEGER,
    parameter int IN_FRACTION    = Q_FRACTION,
    parameter int OUT_DATA_WIDTH = PIXEL_WIDTH,
    parameter int PACK_COUNT     = 4,
    parameter int SAT_CNT_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [IN_INTEGER+IN_FRACTION-1:0]    FP_In,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [PACK_COUNT*OUT_DATA_WIDTH-1:0] out_data,
    output logic [PACK_COUNT-1:0]                out_keep,
    output logic                                 out_last,
    input  logic                                 sat_clear,
    output logic [SAT_CNT_WIDTH-1:0]             sat_count
);

    localparam int IDX_W = (PACK_COUNT > 1) ? $clog2(PACK_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK_COUNT - 1);

    logic [OUT_DATA_WIDTH-1:0] conv_pixel;
    logic                      conv_sat;
    logic                      in_xfer;

    logic                      s1_valid;
    logic [OUT_DATA_WIDTH-1:0] s1_pixel;
    logic                      s1_last;
    logic                      s1_advance;

    logic [IDX_W-1:0]                     idx;
    logic [IDX_W-1:0]                     idx_n;
    logic [PACK_COUNT*OUT_DATA_WIDTH-1:0] data_n;
    logic [PACK_COUNT-1:0]                keep_n;
    logic                                 valid_n;
    logic                                 last_n;

    fp16_to_pixel8_round_sat #(
        .IN_INTEGER     (IN_INTEGER),
        .IN_FRACTION    (IN_FRACTION),
        .OUT_DATA_WIDTH (OUT_DATA_WIDTH)
    ) u_round_sat (
        .fp_in (FP_In),
        .pixel (conv_pixel),
        .sat   (conv_sat)
    );

    assign s1_advance = s1_valid && (!out_valid || out_ready);
    assign in_ready   = !s1_valid || s1_advance;
    assign in_xfer    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_pixel <= '0;
            s1_last  <= 1'b0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_pixel <= conv_pixel;
            s1_last  <= in_last;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // idx==0 means the previous word has been handed off, so a new one begins.
    always_comb begin
        data_n  = out_data;
        keep_n  = out_keep;
        idx_n   = idx;
        valid_n = out_valid;
        last_n  = out_last;
        if (out_valid && out_ready) begin
            valid_n = 1'b0;
        end
        if (s1_advance) begin
            if (idx == '0) begin
                data_n = '0;
                keep_n = '0;
                last_n = 1'b0;
            end
            for (int i = 0; i < PACK_COUNT; i++) begin
                if (IDX_W'(i) == idx) begin
                    data_n[i*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = s1_pixel;
                    keep_n[i] = 1'b1;
                end
            end
            if (idx == LAST_IDX || s1_last) begin
                valid_n = 1'b1;
                last_n  = s1_last;
                idx_n   = '0;
            end else begin
                idx_n = idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            idx       <= '0;
        end else begin
            out_valid <= valid_n;
            out_data  <= data_n;
            out_keep  <= keep_n;
            out_last  <= last_n;
            idx       <= idx_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if (sat_clear) begin
            sat_count <= '0;
        end else if (in_xfer && conv_sat && sat_count != '1) begin
            sat_count <= sat_count + SAT_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fp16_to_pixel8_packer.sv
// tb/tb_fp16_to_pixel8_packer.sv - scoreboard bench for fp16_to_pixel8_packer
module tb_fp16_to_pixel8_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] FP_In = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        sat_clear = 1'b0;
    logic [15:0] sat_count;

    int total = 0;
    int bad = 0;

    logic [36:0] sb[$];
    logic [31:0] m_data = '0;
    logic [3:0]  m_keep = '0;
    int          m_idx = 0;

    fp16_to_pixel8_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .FP_In     (FP_In),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .sat_clear (sat_clear),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [15:0] v, input logic l);
        int s;
        int r;
        logic [7:0] pix;
        s = $signed(v);
        r = (s + 32) >>> 6;
        if (r < 0) pix = 8'd0;
        else if (r > 255) pix = 8'd255;
        else pix = r[7:0];
        if (m_idx == 0) begin
            m_data = '0;
            m_keep = '0;
        end
        m_data[m_idx*8 +: 8] = pix;
        m_keep[m_idx] = 1'b1;
        if (m_idx == 3 || l) begin
            sb.push_back({l, m_keep, m_data});
            m_idx = 0;
        end else begin
            m_idx++;
        end
    endtask

    task automatic send(input logic [15:0] v, input logic l);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        FP_In = v;
        in_last = l;
        #1;
        n = 0;
        while (!in_ready) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $error("FAIL send_timeout observed=stalled expected=in_ready");
                in_valid = 1'b0;
                return;
            end
        end
        model_accept(v, l);
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL drain_timeout observed=%0d expected=0", sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_sat();
        @(negedge clk);
        sat_clear = 1'b1;
        @(negedge clk);
        sat_clear = 1'b0;
        #1 check("sat_clear_idle", 64'(sat_count), 64'd0);
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $error("FAIL unexpected_word observed=%0h expected=none", {out_last, out_keep, out_data});
            end else begin
                logic [36:0] e;
                e = sb.pop_front();
                assert ({out_last, out_keep, out_data} === e) else begin
                    bad++;
                    $error("FAIL word observed=%0h expected=%0h", {out_last, out_keep, out_data}, e);
                end
            end
        end
    end

    initial begin
        logic [31:0] held;
        logic        have;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_keep", 64'(out_keep), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_sat_count", 64'(sat_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Exact values and latency
        send(16'h3FC0, 1'b0);
        send(16'h0000, 1'b0);
        send(16'h1FE0, 1'b0);
        send(16'h0020, 1'b1);
        check("lat_not_early", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 64'(out_valid), 64'd1);
        check("exact_data", 64'(out_data), 64'h0180_00FF);
        check("exact_keep", 64'(out_keep), 64'hF);
        check("exact_last", 64'(out_last), 64'd1);
        drain();
        check("exact_sat", 64'(sat_count), 64'd0);

        // Rounding boundaries
        clear_sat();
        send(16'h001F, 1'b0);
        send(16'h0020, 1'b0);
        send(16'h3FDF, 1'b0);
        send(16'h3FE0, 1'b1);
        @(posedge clk);
        #1 check("round_data", 64'(out_data), 64'hFFFF_0100);
        drain();
        check("round_sat", 64'(sat_count), 64'd1);

        // Negative and overflow
        clear_sat();
        send(16'h8000, 1'b0);
        send(16'hFFE0, 1'b0);
        send(16'h4000, 1'b0);
        send(16'h7FFF, 1'b1);
        @(posedge clk);
        #1 check("negov_data", 64'(out_data), 64'hFFFF_0000);
        drain();
        check("negov_sat", 64'(sat_count), 64'd3);

        // Partial flush
        send(16'h0040, 1'b0);
        send(16'h0080, 1'b1);
        @(posedge clk);
        #1;
        check("partial_data", 64'(out_data), 64'h0000_0201);
        check("partial_keep", 64'(out_keep), 64'h3);
        check("partial_last", 64'(out_last), 64'd1);
        drain();

        // Backpressure with random stream
        have = 1'b0;
        held = '0;
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    send(16'($urandom_range(0, 65535)), (i == 63) || ($urandom_range(0, 7) == 0));
                end
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    #1;
                    if (out_valid && !have) begin
                        held = out_data;
                        have = 1'b1;
                    end else if (have) begin
                        check("bp_hold", 64'(out_data), 64'(held));
                    end
                end
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
                check("bp_word_pending", 64'(have), 64'd1);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-word
        clear_sat();
        send(16'h7FFF, 1'b0);
        send(16'h0040, 1'b0);
        check("pre_rst_sat", 64'(sat_count), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        m_idx = 0;
        sb.delete();
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sat", 64'(sat_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        send(16'h0040, 1'b0);
        send(16'h0080, 1'b0);
        send(16'h00C0, 1'b0);
        send(16'h0100, 1'b1);
        @(posedge clk);
        #1;
        check("post_rst_data", 64'(out_data), 64'h0403_0201);
        check("post_rst_keep", 64'(out_keep), 64'hF);
        drain();

        // sat_clear wins over a concurrent saturating sample
        send(16'h7FFF, 1'b0);
        check("sat_before_clr", 64'(sat_count), 64'd1);
        sat_clear = 1'b1;
        send(16'h8000, 1'b1);
        sat_clear = 1'b0;
        check("sat_clr_prio", 64'(sat_count), 64'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
